// File: rtl/buffer_memory_pkg.sv
// Shared types for the buffer_memory slice.
// Encodes the per-cycle buffer operation as {push, pop}.
package buffer_memory_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

endpackage

// File: rtl/buffer_memory_if.sv
// Producer/consumer bundle of the buffer_memory FIFO.
// master drives data and pops, slave is the buffer itself.
interface buffer_memory_if #(
   parameter int DATA_WIDTH = 40
);

   logic [DATA_WIDTH-1:0] in_data;
   logic                  next_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  empty;
   logic                  full;
   logic                  ready;

   modport master (
      output in_data,
      output next_ready,
      input  out_data,
      input  empty,
      input  full,
      input  ready
   );

   modport slave (
      input  in_data,
      input  next_ready,
      output out_data,
      output empty,
      output full,
      output ready
   );

endinterface

// File: rtl/buffer_memory_ram.sv
// Storage array of buffer_memory: one sync write port,
// one async read port, inferable as distributed/block RAM.
module buffer_memory_ram #(
   parameter int DATA_WIDTH = 40,
   parameter int DATA_DEPTH = 4096,
   localparam int PTR_W     = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PTR_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/buffer_memory.sv
// First-word-fall-through FIFO between a handshake-free producer
// (zero word = idle) and a pulling consumer.
module buffer_memory
   import buffer_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 40,
   parameter int DATA_DEPTH = 4096
) (
   input  logic            clk,
   input  logic            reset,
   buffer_memory_if.slave  bus
);

   localparam int PTR_W = $clog2(DATA_DEPTH);
   localparam int CNT_W = $clog2(DATA_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_DEPTH - 1);

   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  empty;
   logic                  full;
   logic                  push;
   logic                  pop;
   op_e                   op;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DATA_DEPTH));
   assign push  = (|bus.in_data) & ~full;
   assign pop   = bus.next_ready & ~empty;
   assign op    = op_e'({push, pop});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         unique case (op)
            OP_PUSH: count <= count + CNT_W'(1);
            OP_POP:  count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   buffer_memory_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (bus.in_data),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   assign bus.out_data = empty ? '0 : rd_word;
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.ready    = ~full;

endmodule

// File: tb/tb_buffer_memory.sv
// Bench for buffer_memory at depth 5: queue model checked every
// cycle, plus literal expectations along the directed sequence.
module tb_buffer_memory;

   localparam int DW    = 40;
   localparam int DEPTH = 5;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [DW-1:0] q[$];

   buffer_memory_if #(.DATA_WIDTH(DW)) bus ();

   buffer_memory #(
      .DATA_WIDTH (DW),
      .DATA_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Model: a queue of stored words, updated from pre-edge inputs.
   task automatic step(input logic [DW-1:0] d, input logic nr);
      bit do_push;
      bit do_pop;
      bus.in_data    = d;
      bus.next_ready = nr;
      @(posedge clk);
      if (!reset) begin
         do_push = (d != 0) && (q.size() < DEPTH);
         do_pop  = nr && (q.size() > 0);
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      #1;
   endtask

   always @(negedge clk) begin
      chk("cyc_out",   bus.out_data, (q.size() > 0) ? q[0] : '0);
      chk("cyc_empty", DW'(bus.empty), DW'(q.size() == 0));
      chk("cyc_full",  DW'(bus.full),  DW'(q.size() == DEPTH));
      chk("cyc_ready", DW'(bus.ready), DW'(q.size() != DEPTH));
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.in_data    = '0;
      bus.next_ready = 1'b0;
      step(0, 0);
      step(0, 0);
      reset = 1'b0;
      step(0, 0);
      chk("rst_empty", DW'(bus.empty), 1);
      chk("rst_full",  DW'(bus.full),  0);
      chk("rst_ready", DW'(bus.ready), 1);
      chk("rst_out",   bus.out_data,   0);

      step(40'h1, 0);
      step(0, 0);
      chk("p1_empty", DW'(bus.empty), 0);
      chk("p1_out",   bus.out_data,   40'h1);
      step(40'h2, 0);
      chk("p2_out",   bus.out_data,   40'h1);

      step(0, 1);
      chk("pop_out",  bus.out_data,   40'h2);
      step(40'h3, 1);
      chk("pp_out",   bus.out_data,   40'h3);
      step(0, 1);
      chk("pp_empty", DW'(bus.empty), 1);
      chk("pp_zero",  bus.out_data,   0);

      step(40'h4, 0);
      chk("p4_out", bus.out_data, 40'h4);
      step(0, 1);
      chk("p4_empty", DW'(bus.empty), 1);
      step(40'h5, 0);
      chk("p5_out", bus.out_data, 40'h5);
      step(0, 1);
      chk("p5_empty", DW'(bus.empty), 1);
      step(40'h6, 0);
      chk("p6_out",   bus.out_data,   40'h6);
      chk("p6_empty", DW'(bus.empty), 0);
      step(0, 1);

      for (int i = 0; i < 5; i++) step(DW'(40'hA + i), 0);
      chk("fill_full",  DW'(bus.full),  1);
      chk("fill_ready", DW'(bus.ready), 0);
      step(40'hF, 0);
      chk("drop_out", bus.out_data, 40'hA);
      step(40'h20, 1);
      chk("fullpp_out",  bus.out_data,  40'hB);
      chk("fullpp_full", DW'(bus.full), 0);
      step(0, 1);
      step(0, 1);
      step(0, 1);
      step(0, 1);
      chk("drain_empty", DW'(bus.empty), 1);

      for (int i = 0; i < 5; i++) step(DW'(40'hA + i), 0);
      step(40'hF, 0);
      for (int i = 0; i < 5; i++) begin
         chk("wrap_seq", bus.out_data, DW'(40'hA + i));
         step(0, 1);
      end
      chk("wrap_empty", DW'(bus.empty), 1);
      chk("wrap_zero",  bus.out_data,   0);

      step(40'h11, 0);
      step(40'h12, 0);
      step(40'h13, 0);
      reset = 1'b1;
      q.delete();
      #1;
      chk("mid_empty", DW'(bus.empty), 1);
      chk("mid_out",   bus.out_data,   0);
      step(0, 0);
      reset = 1'b0;
      step(40'h7, 0);
      chk("post_out", bus.out_data, 40'h7);
      step(0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
